// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS sequencing controller.
// Holds state codes, the instruction class enum, pc_sel/rf_wsel codes and the
// opcode/funct constants used by the class decoder.
// Latency: n/a (definitions only).  Backpressure: n/a.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_MDW  = 3'd5,
        S_HALT = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU_R,
        CL_ALU_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_J,
        CL_JAL,
        CL_JR,
        CL_JALR,
        CL_MULDIV,
        CL_BREAK,
        CL_UNKNOWN
    } inst_class_t;

    // PC source select
    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] PC_SEL_REG    = 2'd3;

    // Register-file write-back source select
    localparam logic [1:0] WSEL_ALUOUT = 2'd0;
    localparam logic [1:0] WSEL_MDR    = 2'd1;
    localparam logic [1:0] WSEL_LINK   = 2'd2;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BR_LO    = 6'h04;
    localparam logic [5:0] OP_BR_HI    = 6'h07;
    localparam logic [5:0] OP_ALUI_LO  = 6'h08;
    localparam logic [5:0] OP_ALUI_HI  = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LD_LO    = 6'h20;
    localparam logic [5:0] OP_LD_HI    = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // SPECIAL funct codes (IR[5:0])
    localparam logic [5:0] FN_JR       = 6'h08;
    localparam logic [5:0] FN_JALR     = 6'h09;
    localparam logic [5:0] FN_BREAK    = 6'h0D;
    localparam logic [5:0] FN_MD_LO    = 6'h18;
    localparam logic [5:0] FN_MD_HI    = 6'h1B;

    function automatic logic in_range(input logic [5:0] v, input logic [5:0] lo,
                                      input logic [5:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath signal bundle for mc_ctrl_fsm.
// Latency: n/a (wiring only).  Backpressure: dmem_ready / md_done stall the controller.
// Ports: op/funct/branch_cond/dmem_ready/md_done flow datapath -> controller;
//        state, PC/IR/A-B/ALUOut/RF/dmem enables, md_start, instr_change, halted flow
//        controller -> datapath.  master = controller side, slave = datapath side.
//        retire_cnt exists only when MC_RETIRE_CNT_EN is defined.
interface mc_ctrl_fsm_if;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        branch_cond;
    logic        dmem_ready;
    logic        md_done;

    logic [2:0]  state;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        ir_we;
    logic        ab_we;
    logic        aluout_we;
    logic        dmem_re;
    logic        dmem_we;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic        md_start;
    logic        instr_change;
    logic        halted;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    modport master (
        input  op, funct, branch_cond, dmem_ready, md_done,
        output state, pc_we, pc_sel, ir_we, ab_we, aluout_we, dmem_re, dmem_we,
               rf_we, rf_wsel, md_start, instr_change, halted
`ifdef MC_RETIRE_CNT_EN
        , output retire_cnt
`endif
    );

    modport slave (
        output op, funct, branch_cond, dmem_ready, md_done,
        input  state, pc_we, pc_sel, ir_we, ab_we, aluout_we, dmem_re, dmem_we,
               rf_we, rf_wsel, md_start, instr_change, halted
`ifdef MC_RETIRE_CNT_EN
        , input retire_cnt
`endif
    );

endinterface

// File: rtl/mc_ctrl_fsm_inst_class.sv
// Combinational op/funct -> instruction class decoder.
// Latency: 0 cycles (pure combinational).  Backpressure: none.
// Ports: op, funct in; cls out.
module mc_inst_class
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output inst_class_t cls
);

    always_comb begin
        cls = CL_UNKNOWN;
        if (op == OP_SPECIAL) begin
            if (funct == FN_JR)                         cls = CL_JR;
            else if (funct == FN_JALR)                  cls = CL_JALR;
            else if (funct == FN_BREAK)                 cls = CL_BREAK;
            else if (in_range(funct, FN_MD_LO, FN_MD_HI)) cls = CL_MULDIV;
            else                                        cls = CL_ALU_R;
        end else if (op == OP_SPECIAL2) begin
            cls = CL_ALU_R;
        end else if (op == OP_J) begin
            cls = CL_J;
        end else if (op == OP_JAL) begin
            cls = CL_JAL;
        end else if (op == OP_REGIMM || in_range(op, OP_BR_LO, OP_BR_HI)) begin
            cls = CL_BRANCH;
        end else if (in_range(op, OP_ALUI_LO, OP_ALUI_HI)) begin
            cls = CL_ALU_I;
        end else if (in_range(op, OP_LD_LO, OP_LD_HI)) begin
            cls = CL_LOAD;
        end else if (op == OP_SB || op == OP_SH || op == OP_SW) begin
            cls = CL_STORE;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle IF/ID/EX/MEM/WB sequencing controller for the 54-instruction MIPS core.
// Latency: ALU 4, LOAD 5+stall, STORE 4+stall, branch/jump/link 3, MULDIV 4+wait cycles.
// Backpressure: holds in S_MEM until dmem_ready, in S_MDW until md_done (or MD_WAIT_MAX).
// Ports: clk_in, reset (async, active-high) plus bus (mc_ctrl_fsm_if.master).
// Optional: MC_RETIRE_CNT_EN adds bus.retire_cnt, a wrapping retired-instruction count.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MD_WAIT_MAX = 0
) (
    input  logic          clk_in,
    input  logic          reset,
    mc_ctrl_fsm_if.master bus
);

    state_t      state_q;
    inst_class_t cls_q;
    inst_class_t cls_dec;
    logic [31:0] md_cnt;
    logic        md_timeout;
    logic        instr_change_q;

    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        ir_we;
    logic        ab_we;
    logic        aluout_we;
    logic        dmem_re;
    logic        dmem_we;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic        md_start;

    mc_inst_class u_inst_class (
        .op    (bus.op),
        .funct (bus.funct),
        .cls   (cls_dec)
    );

    // md_cnt counts completed S_MDW cycles; a zero limit leaves the wait unbounded.
    assign md_timeout = (MD_WAIT_MAX > 0) && (md_cnt == 32'(MD_WAIT_MAX - 1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q        <= S_IF;
            cls_q          <= CL_UNKNOWN;
            md_cnt         <= '0;
            instr_change_q <= 1'b0;
        end else begin
            // S_IF always advances to S_ID, so this marks exactly that S_ID cycle.
            instr_change_q <= (state_q == S_IF);
            case (state_q)
                S_IF: state_q <= S_ID;
                S_ID: begin
                    cls_q <= cls_dec;
                    if (cls_dec == CL_UNKNOWN)    state_q <= S_IF;
                    else if (cls_dec == CL_BREAK) state_q <= S_HALT;
                    else                          state_q <= S_EX;
                end
                S_EX: begin
                    case (cls_q)
                        CL_ALU_R, CL_ALU_I: state_q <= S_WB;
                        CL_LOAD, CL_STORE:  state_q <= S_MEM;
                        CL_MULDIV: begin
                            state_q <= S_MDW;
                            md_cnt  <= '0;
                        end
                        default:            state_q <= S_IF;
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ready)
                        state_q <= (cls_q == CL_LOAD) ? S_WB : S_IF;
                end
                S_WB: state_q <= S_IF;
                S_MDW: begin
                    if (bus.md_done || md_timeout) state_q <= S_IF;
                    else                           md_cnt  <= md_cnt + 32'd1;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IF;
            endcase
        end
    end

    // Moore decode of state + latched class.  Gated by reset so an in-flight
    // access or write-back is cut off the moment reset rises.
    always_comb begin
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PC4;
        ir_we     = 1'b0;
        ab_we     = 1'b0;
        aluout_we = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = WSEL_ALUOUT;
        md_start  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = PC_SEL_PC4;
                end
                S_ID: ab_we = 1'b1;
                S_EX: begin
                    case (cls_q)
                        CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE: aluout_we = 1'b1;
                        CL_BRANCH: begin
                            pc_we  = bus.branch_cond;
                            pc_sel = PC_SEL_BRANCH;
                        end
                        CL_J: begin
                            pc_we  = 1'b1;
                            pc_sel = PC_SEL_JUMP;
                        end
                        CL_JAL: begin
                            pc_we   = 1'b1;
                            pc_sel  = PC_SEL_JUMP;
                            rf_we   = 1'b1;
                            rf_wsel = WSEL_LINK;
                        end
                        CL_JR: begin
                            pc_we  = 1'b1;
                            pc_sel = PC_SEL_REG;
                        end
                        CL_JALR: begin
                            pc_we   = 1'b1;
                            pc_sel  = PC_SEL_REG;
                            rf_we   = 1'b1;
                            rf_wsel = WSEL_LINK;
                        end
                        CL_MULDIV: md_start = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    dmem_re = (cls_q == CL_LOAD);
                    dmem_we = (cls_q == CL_STORE);
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    rf_wsel = (cls_q == CL_LOAD) ? WSEL_MDR : WSEL_ALUOUT;
                end
                default: ;
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.pc_we        = pc_we;
    assign bus.pc_sel       = pc_sel;
    assign bus.ir_we        = ir_we;
    assign bus.ab_we        = ab_we;
    assign bus.aluout_we    = aluout_we;
    assign bus.dmem_re      = dmem_re;
    assign bus.dmem_we      = dmem_we;
    assign bus.rf_we        = rf_we;
    assign bus.rf_wsel      = rf_wsel;
    assign bus.md_start     = md_start;
    assign bus.instr_change = instr_change_q;
    assign bus.halted       = (state_q == S_HALT);

`ifdef MC_RETIRE_CNT_EN
    logic        retire;
    logic [31:0] retire_cnt_q;

    // An instruction retires on the cycle its last state hands over to S_IF/S_HALT.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_ID:  retire = (cls_dec == CL_UNKNOWN) || (cls_dec == CL_BREAK);
            S_EX:  retire = !((cls_q == CL_ALU_R) || (cls_q == CL_ALU_I) ||
                              (cls_q == CL_LOAD)  || (cls_q == CL_STORE) ||
                              (cls_q == CL_MULDIV));
            S_MEM: retire = bus.dmem_ready && (cls_q == CL_STORE);
            S_WB:  retire = 1'b1;
            S_MDW: retire = bus.md_done || md_timeout;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)       retire_cnt_q <= '0;
        else if (retire) retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    assign bus.retire_cnt = retire_cnt_q;
`endif

endmodule
